// File: rtl/qsystop_nios2_gen2_0_cpu_debug_pkg.sv
// Shared definitions for the Nios II debug host scan engine:
// scan FSM encoding, IR width and codes, default DR length, and state-to-flag decode.
package qsystop_nios2_gen2_0_cpu_debug_pkg;

    localparam int IR_WIDTH         = 2;
    localparam int DEFAULT_DR_WIDTH = 38;

    localparam logic [IR_WIDTH-1:0] IR_OCIMEM    = 2'b00;
    localparam logic [IR_WIDTH-1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [IR_WIDTH-1:0] IR_BREAK     = 2'b10;
    localparam logic [IR_WIDTH-1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5
    } scan_state_e;

    typedef struct packed {
        logic uir;
        logic cdr;
        logic sdr;
        logic udr;
        logic rti;
    } scan_flags_t;

    function automatic scan_flags_t state_flags(input scan_state_e st);
        scan_flags_t f;
        f = '0;
        case (st)
            ST_UIR:  f.uir = 1'b1;
            ST_CDR:  f.cdr = 1'b1;
            ST_SDR:  f.sdr = 1'b1;
            ST_UDR:  f.udr = 1'b1;
            ST_RTI:  f.rti = 1'b1;
            ST_IDLE: f.rti = 1'b1;
            default: f.rti = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/qsystop_nios2_gen2_0_cpu_debug_host_scan_if.sv
// Command/response handshake between a debug requester and the host scan engine.
interface qsystop_nios2_gen2_0_cpu_debug_host_scan_if
    import qsystop_nios2_gen2_0_cpu_debug_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic                cmd_skip_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_dr;

    modport master (
        output cmd_valid, cmd_ir, cmd_skip_ir, cmd_dr,
        input  cmd_ready, rsp_valid, rsp_dr
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_skip_ir, cmd_dr,
        output cmd_ready, rsp_valid, rsp_dr
    );
endinterface

// File: rtl/qsystop_nios2_gen2_0_cpu_debug_host_tckgen.sv
// Divides clk into tck (low phase first) and flags the clk edges on which tck rises or falls.
module qsystop_nios2_gen2_0_cpu_debug_host_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);
    localparam logic [7:0] LAST_CNT = 8'(TCK_DIV - 1);

    logic [7:0] cnt_r;
    logic       tck_r;
    logic       wrap_s;

    assign wrap_s = en && (cnt_r == LAST_CNT);
    assign rise   = wrap_s && !tck_r;
    assign fall   = wrap_s && tck_r;
    assign tck    = tck_r;

    // Half-period counter; disabled means parked low with a cleared count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= 8'd0;
            tck_r <= 1'b0;
        end else if (!en) begin
            cnt_r <= 8'd0;
            tck_r <= 1'b0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= 8'd0;
            tck_r <= ~tck_r;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end
endmodule

// File: rtl/qsystop_nios2_gen2_0_cpu_debug_host_scan.sv
// Host-side virtual-JTAG scan engine: runs one UIR/CDR/SDR/UDR/RTI sequence per accepted
// command, shifting the DR LSB first and returning the captured tdo bits.
module qsystop_nios2_gen2_0_cpu_debug_host_scan
    import qsystop_nios2_gen2_0_cpu_debug_pkg::*;
#(
    parameter int TCK_DIV  = 2,
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    qsystop_nios2_gen2_0_cpu_debug_host_scan_if.slave host,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);
    localparam int               BIT_W    = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DR_WIDTH - 1);

    scan_state_e         state_r, state_nxt_s;
    scan_flags_t         flags_r;
    logic                accept_s, tck_en_s, tck_rise_s, tck_fall_s;
    logic                ready_r, rsp_valid_r, tdi_r;
    logic [IR_WIDTH-1:0] ir_r;
    logic [BIT_W-1:0]    bit_r;
    logic [DR_WIDTH-1:0] dr_lat_r, rsp_dr_r;

    // The accept cycle already counts as the first tck low cycle, so latency is whole periods.
    assign accept_s = host.cmd_valid && ready_r;
    assign tck_en_s = (state_r != ST_IDLE) || accept_s;

    qsystop_nios2_gen2_0_cpu_debug_host_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tck_en_s),
        .tck     (tck),
        .rise    (tck_rise_s),
        .fall    (tck_fall_s)
    );

    // Next-state decode: every active state ends on a tck falling edge.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = host.cmd_skip_ir ? ST_CDR : ST_UIR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UIR:  state_nxt_s = tck_fall_s ? ST_CDR : ST_UIR;
            ST_CDR:  state_nxt_s = tck_fall_s ? ST_SDR : ST_CDR;
            ST_SDR:  state_nxt_s = (tck_fall_s && (bit_r == LAST_BIT)) ? ST_UDR : ST_SDR;
            ST_UDR:  state_nxt_s = tck_fall_s ? ST_RTI : ST_UDR;
            ST_RTI:  state_nxt_s = tck_fall_s ? ST_IDLE : ST_RTI;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Scan FSM, shifter, capture and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            flags_r     <= state_flags(ST_IDLE);
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_dr_r    <= '0;
            dr_lat_r    <= '0;
            tdi_r       <= 1'b0;
            ir_r        <= IR_OCIMEM;
            bit_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            flags_r     <= state_flags(state_nxt_s);
            ready_r     <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_r == ST_RTI) && (state_nxt_s == ST_IDLE);

            if (accept_s) begin
                dr_lat_r <= host.cmd_dr;
                if (!host.cmd_skip_ir) begin
                    ir_r <= host.cmd_ir;
                end
            end else if (tck_fall_s && (state_r == ST_SDR) && (state_nxt_s == ST_SDR)) begin
                dr_lat_r <= {1'b0, dr_lat_r[DR_WIDTH-1:1]};
            end

            // tdi moves only at the start of a low phase, so it is stable across every rise.
            if (tck_fall_s && (state_nxt_s == ST_SDR)) begin
                tdi_r <= (state_r == ST_SDR) ? dr_lat_r[1] : dr_lat_r[0];
            end else if (tck_fall_s) begin
                tdi_r <= 1'b0;
            end

            if (tck_fall_s) begin
                bit_r <= ((state_r == ST_SDR) && (state_nxt_s == ST_SDR)) ? bit_r + BIT_W'(1) : '0;
            end

            if (tck_rise_s && (state_r == ST_SDR)) begin
                rsp_dr_r[bit_r] <= tdo;
            end
        end
    end

    assign host.cmd_ready = ready_r;
    assign host.rsp_valid = rsp_valid_r;
    assign host.rsp_dr    = rsp_dr_r;
    assign tdi            = tdi_r;
    assign ir_in          = ir_r;
    assign vs_uir         = flags_r.uir;
    assign vs_cdr         = flags_r.cdr;
    assign vs_sdr         = flags_r.sdr;
    assign vs_udr         = flags_r.udr;
    assign jtag_state_rti = flags_r.rti;
endmodule

// File: doc/qsystop_nios2_gen2_0_cpu_debug_host_scan.md
QSYSTOP_NIOS2_GEN2_0_CPU_DEBUG_HOST_SCAN -- requirements
Module: qsystop_nios2_gen2_0_cpu_debug_host_scan

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning clk cycles per tck half-period (legal 1..255).
REQ-002 SHALL have parameter DR_WIDTH, default 38, meaning debug data-register scan length.
REQ-003 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports: cmd_valid  input  1  scan request; cmd_ready  output  1  request accepted when both high.
REQ-006 SHALL have ports: cmd_ir  input  2  IR value; cmd_skip_ir  input  1  omit UIR phase; cmd_dr  input  DR_WIDTH  shift-in data.
REQ-007 SHALL have ports: rsp_valid  output  1  one-cycle completion pulse; rsp_dr  output  DR_WIDTH  captured tdo data.
REQ-008 SHALL have ports: tck  output  1; tdi  output  1; tdo  input  1; ir_in  output  2; vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti  output  1 each (virtual-JTAG target side).

Function
REQ-009 SHALL implement FSM IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> IDLE; UIR skipped (IDLE -> CDR) when cmd_skip_ir latched high.
REQ-010 SHALL assert cmd_ready only in IDLE; accept latches cmd_ir, cmd_skip_ir, cmd_dr into internal registers.
REQ-011 SHALL hold tck low in IDLE; in all other states toggle tck every TCK_DIV clk cycles, each tck period low phase first.
REQ-012 SHALL occupy exactly one tck period in UIR, CDR, UDR, RTI and exactly DR_WIDTH tck periods in SDR.
REQ-013 SHALL assert the vs_* flag matching the current state (vs_uir/UIR, vs_cdr/CDR, vs_sdr/SDR, vs_udr/UDR), jtag_state_rti in RTI and IDLE; flags change only on clk cycles where tck falls or the FSM leaves IDLE.
REQ-014 SHALL drive ir_in from latched cmd_ir from UIR entry onward and hold it until the next UIR; held unchanged when UIR skipped.
REQ-015 SHALL shift LSB first: tdi = latched DR bit k during SDR period k, updated at the start of each tck low phase.
REQ-016 SHALL sample tdo on the clk cycle tck rises in SDR period k into rsp_dr[k]; tdo ignored outside SDR.
REQ-017 SHALL pulse rsp_valid for one clk on the cycle FSM re-enters IDLE; rsp_dr stable from that cycle until next SDR starts.
REQ-018 SHALL give latency from accept cycle to rsp_valid of (nperiods*2*TCK_DIV) clk cycles, nperiods = DR_WIDTH+4 (DR_WIDTH+3 with skip).
REQ-019 SHALL allow back-to-back: cmd_ready high in rsp_valid cycle; new accept that cycle starts next scan immediately.
REQ-020 SHALL ignore cmd_valid while not IDLE; cmd_* may change freely after accept.

Reset
REQ-021 SHALL on reset_n low at a clk edge: FSM IDLE, tck 0, tdi 0, ir_in 0, vs_* 0, jtag_state_rti 1, cmd_ready 1 after release, rsp_valid 0, rsp_dr 0, tck divider and bit counter 0.
REQ-022 SHALL abort any scan in progress on reset with no rsp_valid and discarded partial data.

Structure
REQ-023 SHALL place FSM state encoding, IR width (2), default DR_WIDTH (38), and IR codes in shared package qsystop_nios2_gen2_0_cpu_debug_pkg.
REQ-024 SHALL implement tck generation in one sub-module qsystop_nios2_gen2_0_cpu_debug_host_tckgen providing tck, rise and fall strobes; FSM and shifter in the top.

Verification
REQ-025 Reset: hold reset_n low 3 cycles mid-SDR -> tck 0, vs_* 0, rsp_valid never pulses, cmd_ready 1 after release.
REQ-026 Full scan, TCK_DIV 2, cmd_ir 2'b01, cmd_dr 38'h15_5555_5555, tdo looped to tdi -> ir_in 2'b01, rsp_valid exactly 168 clk after accept, rsp_dr 38'h15_5555_5555.
REQ-027 Skip IR, TCK_DIV 2, after prior ir_in 2'b10 -> no vs_uir, ir_in stays 2'b10, rsp_valid 164 clk after accept.
REQ-028 TCK_DIV 1, tdo tied 1 -> tck toggles every clk, rsp_dr all ones, rsp_valid 84 clk after accept.
REQ-029 Back-to-back: cmd_valid held high with two commands -> second accepted in first rsp_valid cycle, tck stays low only 0 cycles between scans, two rsp_valid pulses 168 clk apart.
REQ-030 Protocol checker: exactly one vs_* high per active state, vs_sdr high for 38 tck periods, tdi stable while tck high.
